// File: rtl/trip_pkg.sv
// trip_pkg: shared definitions for the trip-event emulator.
//   - trip_state_t : sequencer states (IDLE, RUN1, RUN2, HOLD)
//   - TRIP_CNT_W   : default width of delays and run counter
//   - TRIP_HOLD_CYC: default number of cycles both trip lines stay high
// These defaults are also used by the getCycles benches so that both sides
// agree on counter width and hold length.
package trip_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN1 = 2'd1,
        RUN2 = 2'd2,
        HOLD = 2'd3
    } trip_state_t;

    localparam int TRIP_CNT_W    = 32;
    localparam int TRIP_HOLD_CYC = 16;

endpackage : trip_pkg

// File: rtl/trip_timer.sv
// trip_timer: loadable up-counter with equality match.
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset (counter -> 0)
//   clr       - synchronous clear (highest priority after reset)
//   load      - synchronous load of load_val
//   load_val  - value loaded when load is high
//   en        - count enable (+1 per cycle)
//   match_val - compare value
//   match     - high while the current count equals match_val
module trip_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] match_val,
    output logic         match
);

    logic [W-1:0] count_r;

    // Counter register: clear beats load beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Equality compare against the currently selected delay.
    always_comb begin
        match = (count_r == match_val);
    end

endmodule : trip_timer

// File: rtl/trip_emulator.sv
// trip_emulator: programmable trip-event generator for the getCycles path.
// On an accepted start it latches two delays and raises trippedone/trippedtwo
// exactly delay1/delay2 cycles after the start edge, holds both high for
// HOLD_CYC cycles after trippedtwo rises, then releases them and pulses done.
// Ports:
//   CLK           - clock, rising edge
//   RST           - asynchronous reset, active-low
//   startSequence - arm request, honoured only while idle and abort is low
//   abort         - synchronous cancel back to idle, no done
//   delay1/delay2 - cycle delays, sampled at the start edge
//   trippedone    - emulated first sensor trip (registered)
//   trippedtwo    - emulated second sensor trip (registered)
//   busy          - high whenever a sequence is in progress
//   done          - one-cycle pulse on normal completion
//   cfgErr        - sticky: latched delay2 was below delay1
module trip_emulator
    import trip_pkg::*;
#(
    parameter int CNT_W    = TRIP_CNT_W,
    parameter int HOLD_CYC = TRIP_HOLD_CYC
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             startSequence,
    input  logic             abort,
    input  logic [CNT_W-1:0] delay1,
    input  logic [CNT_W-1:0] delay2,
    output logic             trippedone,
    output logic             trippedtwo,
    output logic             busy,
    output logic             done,
    output logic             cfgErr
);

    localparam int HOLD_W = 16;

    trip_state_t       state_r, state_s;
    logic [CNT_W-1:0]  d1_r, d1_s;
    logic [CNT_W-1:0]  d2_r, d2_s;
    logic [HOLD_W-1:0] hold_r, hold_s;
    logic              trip1_r, trip1_s;
    logic              trip2_r, trip2_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              cfg_err_r, cfg_err_s;

    logic [CNT_W-1:0]  eff1_s, eff2_s;
    logic [CNT_W-1:0]  match_val_s;
    logic              tmr_clr_s, tmr_load_s, tmr_en_s, tmr_match_s;

    // The run counter is loaded with 1 at the start edge, so just before
    // edge E0+k it holds k and an equality match fires exactly on edge E0+k.
    trip_timer #(
        .W (CNT_W)
    ) u_run_timer (
        .clk       (CLK),
        .rst_n     (RST),
        .clr       (tmr_clr_s),
        .load      (tmr_load_s),
        .load_val  (CNT_W'(1)),
        .en        (tmr_en_s),
        .match_val (match_val_s),
        .match     (tmr_match_s)
    );

    // Effective delays: zero counts as one.
    always_comb begin
        if (delay1 == {CNT_W{1'b0}}) begin
            eff1_s = CNT_W'(1);
        end else begin
            eff1_s = delay1;
        end
        if (delay2 == {CNT_W{1'b0}}) begin
            eff2_s = CNT_W'(1);
        end else begin
            eff2_s = delay2;
        end
    end

    // Compare target follows the phase of the sequence.
    always_comb begin
        if (state_r == RUN1) begin
            match_val_s = d1_r;
        end else begin
            match_val_s = d2_r;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s    = state_r;
        d1_s       = d1_r;
        d2_s       = d2_r;
        hold_s     = hold_r;
        trip1_s    = trip1_r;
        trip2_s    = trip2_r;
        done_s     = 1'b0;
        cfg_err_s  = cfg_err_r;
        tmr_clr_s  = 1'b0;
        tmr_load_s = 1'b0;
        tmr_en_s   = 1'b0;

        case (state_r)
            IDLE: begin
                if (startSequence && !abort) begin
                    state_s    = RUN1;
                    d1_s       = eff1_s;
                    tmr_load_s = 1'b1;
                    hold_s     = {HOLD_W{1'b0}};
                    trip1_s    = 1'b0;
                    trip2_s    = 1'b0;
                    if (eff2_s < eff1_s) begin
                        d2_s      = eff1_s;
                        cfg_err_s = 1'b1;
                    end else begin
                        d2_s      = eff2_s;
                        cfg_err_s = 1'b0;
                    end
                end else begin
                    state_s = IDLE;
                end
            end

            RUN1: begin
                if (abort) begin
                    state_s   = IDLE;
                    trip1_s   = 1'b0;
                    trip2_s   = 1'b0;
                    tmr_clr_s = 1'b1;
                end else if (tmr_match_s) begin
                    trip1_s = 1'b1;
                    if (d2_r == d1_r) begin
                        trip2_s = 1'b1;
                        state_s = HOLD;
                        hold_s  = {HOLD_W{1'b0}};
                    end else begin
                        state_s  = RUN2;
                        tmr_en_s = 1'b1;
                    end
                end else begin
                    tmr_en_s = 1'b1;
                end
            end

            RUN2: begin
                if (abort) begin
                    state_s   = IDLE;
                    trip1_s   = 1'b0;
                    trip2_s   = 1'b0;
                    tmr_clr_s = 1'b1;
                end else if (tmr_match_s) begin
                    trip2_s = 1'b1;
                    state_s = HOLD;
                    hold_s  = {HOLD_W{1'b0}};
                end else begin
                    tmr_en_s = 1'b1;
                end
            end

            HOLD: begin
                if (abort) begin
                    state_s   = IDLE;
                    trip1_s   = 1'b0;
                    trip2_s   = 1'b0;
                    tmr_clr_s = 1'b1;
                end else if (hold_r == HOLD_W'(HOLD_CYC - 1)) begin
                    state_s   = IDLE;
                    trip1_s   = 1'b0;
                    trip2_s   = 1'b0;
                    done_s    = 1'b1;
                    tmr_clr_s = 1'b1;
                end else begin
                    hold_s = hold_r + HOLD_W'(1);
                end
            end

            default: begin
                state_s   = IDLE;
                trip1_s   = 1'b0;
                trip2_s   = 1'b0;
                tmr_clr_s = 1'b1;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r   <= IDLE;
            d1_r      <= {CNT_W{1'b0}};
            d2_r      <= {CNT_W{1'b0}};
            hold_r    <= {HOLD_W{1'b0}};
            trip1_r   <= 1'b0;
            trip2_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            cfg_err_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            d1_r      <= d1_s;
            d2_r      <= d2_s;
            hold_r    <= hold_s;
            trip1_r   <= trip1_s;
            trip2_r   <= trip2_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            cfg_err_r <= cfg_err_s;
        end
    end

    assign trippedone = trip1_r;
    assign trippedtwo = trip2_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign cfgErr     = cfg_err_r;

endmodule : trip_emulator

// File: tb/tb_trip_emulator.sv
// tb_trip_emulator: self-checking bench for trip_emulator (HOLD_CYC = 4).
// Each sequence is predicted from its delays with plain arithmetic: after
// edge E0+k the trip lines, busy, done and cfgErr follow directly from the
// effective delays, the hold length and an optional abort point.
module tb_trip_emulator;

    localparam int  HOLD = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abrt;
    logic [31:0] delay1;
    logic [31:0] delay2;
    logic        trippedone;
    logic        trippedtwo;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int   errors = 0;
    int   checks = 0;
    logic last_cfg = 1'b0;

    trip_emulator #(
        .CNT_W    (32),
        .HOLD_CYC (HOLD)
    ) dut (
        .CLK           (clk),
        .RST           (rst),
        .startSequence (start),
        .abort         (abrt),
        .delay1        (delay1),
        .delay2        (delay2),
        .trippedone    (trippedone),
        .trippedtwo    (trippedtwo),
        .busy          (busy),
        .done          (done),
        .cfgErr        (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {trippedone, trippedtwo, busy, done, cfgErr} after edge E0+k.
    function automatic logic [4:0] model(input longint k, input longint e1,
                                         input longint e2, input longint ab,
                                         input logic cfg);
        longint fin;
        fin = e2 + HOLD;
        if (ab > 0 && k >= ab)
            return {4'b0000, cfg};
        return {(k >= e1) && (k < fin), (k >= e2) && (k < fin),
                (k < fin), (k == fin), cfg};
    endfunction

    task automatic chk(input string tag, input longint k,
                       input logic [4:0] exp_v);
        logic [4:0] obs;
        obs = {trippedone, trippedtwo, busy, done, cfg_err};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s k=%0d observed t1,t2,busy,done,cfg=%b expected=%b",
                   tag, k, obs, exp_v);
        end
    endtask

    // Effective delays for a start with raw d1/d2.
    task automatic eff(input logic [31:0] d1, input logic [31:0] d2,
                       output longint e1, output longint e2, output logic cfg);
        e1  = (d1 == 32'd0) ? 64'd1 : longint'(d1);
        e2  = (d2 == 32'd0) ? 64'd1 : longint'(d2);
        cfg = (e2 < e1);
        if (e2 < e1) e2 = e1;
    endtask

    // One start at the next edge, then per-cycle checks until the sequence
    // ends plus `tail` idle cycles. Caller guarantees the DUT is idle.
    task automatic run_seq(input string tag, input logic [31:0] d1,
                           input logic [31:0] d2, input int abort_at,
                           input int restart_at, input int tail);
        longint e1, e2, last;
        logic   cfg;
        eff(d1, d2, e1, e2, cfg);
        last = ((abort_at > 0) ? longint'(abort_at) : e2 + HOLD) + tail;
        delay1 = d1;
        delay2 = d2;
        start  = 1'b1;
        abrt   = 1'b0;
        @(posedge clk); #1;
        start  = 1'b0;
        delay1 = $urandom;
        delay2 = $urandom;
        chk(tag, 0, model(0, e1, e2, abort_at, cfg));
        for (longint k = 1; k <= last; k++) begin
            abrt  = (k == abort_at);
            start = (k == restart_at);
            @(posedge clk); #1;
            abrt  = 1'b0;
            start = 1'b0;
            chk(tag, k, model(k, e1, e2, abort_at, cfg));
        end
        last_cfg = cfg;
    endtask

    initial begin
        longint e1, e2, fin;
        logic   cfg;
        int     ab, rs;
        logic [31:0] r1, r2;

        rst    = 1'b1;
        start  = 1'b0;
        abrt   = 1'b0;
        delay1 = 32'd0;
        delay2 = 32'd0;
        #2 rst = 1'b0;
        #1 chk("reset", 0, 5'b00000);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", 0, 5'b00000);

        // Directed sequences.
        run_seq("basic", 32'd10, 32'd25, 0, 0, 2);
        run_seq("zero_delays", 32'd0, 32'd0, 0, 0, 1);
        run_seq("inverted", 32'd40, 32'd20, 0, 0, 1);
        run_seq("cfg_clear", 32'd5, 32'd7, 0, 0, 1);
        run_seq("abort", 32'd10, 32'd50, 15, 0, 2);
        run_seq("restart_ignored", 32'd10, 32'd25, 0, 18, 0);
        run_seq("back_to_back", 32'd3, 32'd3, 0, 0, 1);

        // abort and start together while idle: nothing starts.
        start  = 1'b1;
        abrt   = 1'b1;
        delay1 = 32'd2;
        delay2 = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        abrt  = 1'b0;
        chk("abort_beats_start", 0, {4'b0000, last_cfg});
        @(posedge clk); #1;
        chk("abort_beats_start", 1, {4'b0000, last_cfg});

        // Long delta for loopback into the measurement path.
        run_seq("loopback", 32'd100, 32'd12600, 0, 0, 1);

        // Asynchronous reset in the middle of HOLD (cfgErr also set).
        eff(32'd9, 32'd3, e1, e2, cfg);
        delay1 = 32'd9;
        delay2 = 32'd3;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 chk("pre_reset_hold", 10, model(10, e1, e2, 0, cfg));
        #2 rst = 1'b0;
        #1 chk("async_reset", 10, 5'b00000);
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_release_idle", 0, 5'b00000);
        run_seq("after_reset", 32'd5, 32'd6, 0, 0, 1);

        // Randomized sequences.
        for (int i = 0; i < 25; i++) begin
            r1 = $urandom_range(0, 40);
            r2 = $urandom_range(0, 60);
            eff(r1, r2, e1, e2, cfg);
            fin = e2 + HOLD;
            ab  = 0;
            rs  = 0;
            if ($urandom_range(0, 3) == 0)
                ab = $urandom_range(1, int'(fin));
            if ($urandom_range(0, 2) == 0)
                rs = $urandom_range(1, (ab > 0) ? ab : int'(fin));
            run_seq("random", r1, r2, ab, rs, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_trip_emulator

// File: doc/trip_emulator.md
# trip_emulator

Programmable trip-event generator that drives the `trippedone`/`trippedtwo` sensor lines of the cycle-measurement path (`getCycles`) from software-chosen delays. It replaces the physical sensor pair during bring-up, regression, and self-test. On a start request it latches two cycle delays and raises each trip line at the exact programmed cycle, so a known delta can be read back from the measurement counters.

## Interface
- `CNT_W`, 32: width of delays and the internal counter.
- `HOLD_CYC`, 16: cycles both trip lines stay high after `trippedtwo` rises, before release; legal range 1..2^16-1.

Ports:
- `CLK` input 1: single clock; all logic is on the rising edge.
- `RST` input 1: asynchronous reset, active-low.
- `startSequence` input 1: arm request, sampled high while IDLE.
- `abort` input 1: synchronous cancel; forces return to IDLE.
- `delay1` input CNT_W: cycles from start to `trippedone`; sampled at start.
- `delay2` input CNT_W: cycles from start to `trippedtwo`; sampled at start.
- `trippedone` output 1: emulated first sensor trip, registered.
- `trippedtwo` output 1: emulated second sensor trip, registered.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when a sequence completes normally.
- `cfgErr` output 1: sticky; set if latched `delay2` < latched `delay1`; cleared by the next accepted start.

## Operation
- Reset (`RST`=0) takes effect immediately:
  - State goes to IDLE; counter and hold counter clear.
  - All outputs go to 0, including `cfgErr`.
- States: IDLE, RUN1, RUN2, HOLD.
- IDLE:
  - If `startSequence`=1 and `abort`=0, the edge at which it is sampled is the start edge E0.
  - At E0: latch `delay1`/`delay2` as d1/d2, clear the counter, set `busy`, compute `cfgErr`, and go to RUN1.
- Delay rules:
  - A latched delay of 0 is treated as 1.
  - If d2 < d1, d2 is replaced by d1 and `cfgErr` is set.
- RUN1: counter increments each cycle; at edge E0+d1, `trippedone` goes 1 and the state goes to RUN2.
  - If d2 == d1, `trippedtwo` also goes 1 on the same edge and the state goes straight to HOLD.
- RUN2: at edge E0+d2, `trippedtwo` goes 1 and the state goes to HOLD; `trippedone` stays 1.
- HOLD:
  - Hold counter runs `HOLD_CYC` cycles.
  - On the final edge, both trip lines go 0, `done` pulses for one cycle, and the state goes to IDLE.
- Counter: CNT_W bits, compared for equality. Maximum delay is 2^CNT_W-1, so the counter cannot wrap.
- `abort`=1 in any non-IDLE state: on the next edge, trip lines go 0, state goes to IDLE, `busy` goes 0, and no `done` is produced.
- `startSequence` while `busy`=1 is ignored and not queued.
- `abort` and `startSequence` high together in IDLE: abort wins and nothing starts.
- `delay1`/`delay2` changes after E0 have no effect until the next start.

## Timing
- Trip latency is exact: `trippedone` is first high after edge E0+d1, `trippedtwo` after edge E0+d2.
- Both trip lines are registered outputs with no combinational path from inputs.
- `busy` rises at E0 and falls on the same edge that `done` rises.
- `done` is high exactly one cycle.
- Earliest restart: `startSequence` sampled on the edge after `done`.
- Sequence length from E0 to IDLE: d2 + `HOLD_CYC` cycles.

## Structure
- Package `trip_pkg` holds:
  - State enum `trip_state_t` {IDLE, RUN1, RUN2, HOLD}.
  - Default `CNT_W` and `HOLD_CYC` constants, shared with `getCycles` benches.
- Sub-module `trip_timer`: loadable CNT_W up-counter with clear, enable, and an equality-match output, instantiated once for the run counter. The hold counter stays inline.

## Test plan
- Basic sequence: `delay1`=10, `delay2`=25, `HOLD_CYC`=4, one-cycle start.
  - Required: `trippedone` rises at E0+10, `trippedtwo` at E0+25.
  - Required: both fall and `done` pulses at E0+29; `cfgErr`=0.
- Loopback into `getCycles`: `delay1`=100, `delay2`=12600.
  - Required: `hasTripped` asserts; `theCount2`−`theCount1` = 12500.
- Boundaries: `delay1`=0 and `delay2`=0.
  - Required: both lines rise at E0+1; `cfgErr`=0.
- Inverted delays: `delay1`=40, `delay2`=20.
  - Required: both lines rise at E0+40, `cfgErr`=1.
  - Required: the next start with valid delays clears `cfgErr`.
- Abort and busy-ignore:
  - `abort` at E0+15 with d1=10, d2=50: lines go 0 at E0+16, no `done`, `busy`=0.
  - `startSequence` pulsed during RUN2 is ignored; sequence timing is unchanged.
- Asynchronous reset mid-HOLD: `RST` driven low between edges.
  - Required: all outputs go 0 immediately, before the next edge.
  - Required: after release, a fresh start with d1=5, d2=6 behaves nominally.
